emu_fetch_sequencer: RTL and testbench
======================================

Name: emu_fetch_sequencer

Overview:
- Fetch/execute sequencer for the Thumb-subset emulator core.
- Owns the PC and the single 32-bit-wide word memory port.
- Shares that port between instruction fetch and execute-unit load/store requests.
- Presents one 16-bit instruction at a time to the decode/execute unit, then waits for it to retire before fetching the next.

Parameters:
ADDR_W, 10, word-address width (1024 x 32-bit words)
RESET_PC, 32'h0000_0000, byte address of first instruction after run

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
run  in  1  start execution; sampled only in IDLE
mem_addr  out  ADDR_W  word address to memory
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid when mem_ready=1
mem_ready  in  1  memory completes the current request this cycle
instr  out  16  instruction to decode
instr_valid  out  1  one-cycle pulse, instr valid
pc  out  32  byte address of the current instruction
exec_done  in  1  execute unit retires the current instruction
exec_branch  in  1  qualifies exec_done: take exec_target
exec_target  in  32  branch target byte address
exec_halt  in  1  qualifies exec_done: stop (SVC 100)
dreq  in  1  execute-unit data access request
dwe  in  1  1 = store, 0 = load
daddr  in  32  data byte address
dwdata  in  32  store data
drdata  out  32  load data, valid with dack
dack  out  1  one-cycle data-access completion pulse
halted  out  1  sequencer stopped (HALT or FAULT)
fault  out  1  address fault occurred
retired  out  32  count of retired instructions

Behaviour:
- Reset values:
  - state=IDLE, pc=RESET_PC.
  - mem_rd=mem_wr=0; mem_addr, mem_wdata, drdata=0.
  - instr=0, instr_valid=0, dack=0.
  - halted=0, fault=0, retired=0.
  - Fetch buffer invalid.
- States: IDLE, FETCH, FWAIT, ISSUE, EXEC, DWAIT, HALT, FAULT.
- IDLE: run=1 -> FETCH.
- FETCH:
  - pc[31:ADDR_W+2]!=0 or pc[0]=1 -> FAULT.
  - Buffer valid and buffer tag==pc[ADDR_W+1:2] -> ISSUE (hit, no memory access).
  - Else assert mem_rd with mem_addr=pc[ADDR_W+1:2] -> FWAIT.
- FWAIT:
  - Hold mem_rd/mem_addr stable until mem_ready.
  - On mem_ready: load buffer (data + tag), drop mem_rd next cycle -> ISSUE.
- ISSUE:
  - instr = pc[1] ? word[31:16] : word[15:0].
  - instr_valid=1 for exactly this cycle -> EXEC.
- EXEC (dreq has priority over exec_done in the same cycle):
  - dreq=1:
    - daddr[1:0]!=0 or daddr[31:ADDR_W+2]!=0 -> FAULT.
    - Else drive mem_rd or mem_wr (per dwe), mem_addr=daddr[ADDR_W+1:2], mem_wdata=dwdata -> DWAIT.
  - exec_done=1 with exec_halt -> HALT; pc unchanged; retired+1.
  - exec_done=1 with exec_branch -> pc=exec_target & ~1; retired+1 -> FETCH.
  - exec_done=1 otherwise -> pc=pc+2 (32-bit wrap); retired+1 -> FETCH.
  - exec_done with both halt and branch: halt wins.
- DWAIT:
  - Hold request stable until mem_ready.
  - On mem_ready: dack=1 for one cycle, drdata=mem_rdata (load) or 0 (store) -> EXEC.
  - Store whose word address equals the buffer tag invalidates the buffer (self-modifying code).
- HALT: halted=1. FAULT: halted=1, fault=1. Both are sticky until reset; run is ignored.
- mem_rd and mem_wr are never both 1.
- retired wraps at 2^32.
- Reset mid-transaction: requests drop on the reset edge; memory must tolerate an abandoned request.
- Latency, zero-wait memory (mem_ready same cycle as request):
  - Buffer miss: FETCH->FWAIT->ISSUE gives instr_valid 3 cycles after entering FETCH... counting from the FETCH cycle, instr_valid is in the 3rd cycle.
  - Buffer hit: instr_valid in the 2nd cycle.

Decomposition:
- Shared package emu_pkg:
  - State encoding enum.
  - Constants: WORD_BYTES=4, HALF_BYTES=2, SVC_HALT=8'd100.
  - Typedef for the word address: logic [ADDR_W-1:0].
- One natural sub-module, emu_fetch_buffer:
  - Holds 1-entry tag/data/valid.
  - Ports for lookup, fill, and store-snoop invalidate.

Test Plan:
1. reset, run=1, memory word0=32'h2001_2002, zero-wait mem -> instr_valid with instr=16'h2002, pc=0; exec_done -> instr=16'h2001, pc=2, and no mem_rd pulse (buffer hit); retired=2 after the second exec_done.
2. Branch: exec_done+exec_branch, exec_target=32'h0000_0011 -> next mem_addr=4, pc=32'h10, instr=word4[15:0].
3. Load during EXEC: dreq=1, dwe=0, daddr=32'h40, word16=32'hDEAD_BEEF, mem_ready delayed 3 cycles -> mem_rd held 3 cycles at mem_addr=16, one dack pulse with drdata=32'hDEAD_BEEF, then return to EXEC.
4. Store to the current fetch word (daddr=pc&~3, dwdata=32'h1234_5678), then exec_done -> the next fetch issues mem_rd (buffer invalidated); instr=16'h1234 when pc[1]=1.
5. Faults: dreq with daddr=32'h42 -> fault=1, halted=1, no mem_wr/mem_rd; separately, branch target 32'h0000_1000 (out of range, ADDR_W=10) -> FAULT on the next FETCH.
6. exec_done+exec_halt -> halted=1, pc unchanged, run ignored; assert reset for 1 cycle mid-FWAIT -> all outputs return to reset values and state=IDLE.

Source files
------------

// File: rtl/emu_pkg.sv
// Shared definitions for the Thumb-subset emulator core.
//
// Contents:
//   seq_state_t  - fetch/execute sequencer state encoding
//   constants    - word/halfword sizes, halt SVC number, default address width
//   word_addr_t  - word address into the 32-bit memory
//   pick_half    - selects the 16-bit instruction half of a memory word
package emu_pkg;

  localparam int         EMU_ADDR_W = 10;
  localparam int         WORD_BYTES = 4;
  localparam int         HALF_BYTES = 2;
  localparam logic [7:0] SVC_HALT   = 8'd100;

  typedef logic [EMU_ADDR_W-1:0] word_addr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FWAIT,
    S_ISSUE,
    S_EXEC,
    S_DWAIT,
    S_HALT,
    S_FAULT
  } seq_state_t;

  // Thumb instructions are little-endian halfwords: byte address bit 1 picks
  // the upper half of the word.
  function automatic logic [15:0] pick_half(input logic [31:0] word, input logic upper);
    return upper ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/emu_fetch_buffer.sv
// Single-entry instruction word buffer for the fetch sequencer.
//
// Ports:
//   clock, reset       - clock and synchronous active-high reset
//   i_lookup_tag       - word address of the current PC
//   o_hit, o_data      - buffer holds that word / its contents
//   i_fill*            - load a freshly fetched word and its tag
//   i_snoop_wr/_tag    - completed store; drops the entry if it hits the tag
module emu_fetch_buffer #(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_lookup_tag,
  output logic              o_hit,
  output logic [31:0]       o_data,
  input  logic              i_fill,
  input  logic [ADDR_W-1:0] i_fill_tag,
  input  logic [31:0]       i_fill_data,
  input  logic              i_snoop_wr,
  input  logic [ADDR_W-1:0] i_snoop_tag
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_tag;
  logic [31:0]       r_data;

  assign o_hit  = r_valid && (r_tag == i_lookup_tag);
  assign o_data = r_data;

  // A store into the buffered word must force a refetch so self-modifying
  // code sees its own writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_tag;
      r_data  <= i_fill_data;
    end else if (i_snoop_wr && (i_snoop_tag == r_tag)) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/emu_fetch_sequencer.sv
// Fetch/execute sequencer: owns the PC and the single word memory port,
// sharing it between instruction fetch and execute-unit loads/stores.
//
// Ports:
//   clock, reset                    - clock, synchronous active-high reset
//   run                             - start execution from IDLE
//   mem_addr/rd/wr/wdata/rdata/ready- word memory port
//   instr, instr_valid, pc          - instruction presented to decode
//   exec_done/branch/target/halt    - execute unit retire interface
//   dreq, dwe, daddr, dwdata        - execute unit data access request
//   drdata, dack                    - data access completion
//   halted, fault, retired          - status
module emu_fetch_sequencer
  import emu_pkg::*;
#(
  parameter int          ADDR_W   = EMU_ADDR_W,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic [31:0]       pc,
  input  logic              exec_done,
  input  logic              exec_branch,
  input  logic [31:0]       exec_target,
  input  logic              exec_halt,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [31:0]       daddr,
  input  logic [31:0]       dwdata,
  output logic [31:0]       drdata,
  output logic              dack,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       retired
);

  localparam int OFS_W = $clog2(WORD_BYTES);

  seq_state_t        r_state;
  logic [31:0]       r_pc;
  logic [31:0]       r_retired;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_drdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [15:0]       r_instr;
  logic              r_instr_valid;
  logic              r_dack;
  logic              r_halted;
  logic              r_fault;

  logic [ADDR_W-1:0] w_pc_word;
  logic              w_pc_bad;
  logic              w_daddr_bad;
  logic              w_hit;
  logic [31:0]       w_buf_data;
  logic              w_fill;
  logic              w_snoop;

  // Instruction fetches must be halfword aligned and data accesses word
  // aligned; anything above the implemented memory is a fault.
  assign w_pc_word   = r_pc[ADDR_W+OFS_W-1:OFS_W];
  assign w_pc_bad    = (r_pc[31:ADDR_W+OFS_W] != '0) || r_pc[0];
  assign w_daddr_bad = (daddr[OFS_W-1:0] != '0) || (daddr[31:ADDR_W+OFS_W] != '0);
  assign w_fill      = (r_state == S_FWAIT) && mem_ready;
  assign w_snoop     = (r_state == S_DWAIT) && mem_ready && r_mem_wr;

  emu_fetch_buffer #(.ADDR_W(ADDR_W)) u_buffer (
    .clock        (clock),
    .reset        (reset),
    .i_lookup_tag (w_pc_word),
    .o_hit        (w_hit),
    .o_data       (w_buf_data),
    .i_fill       (w_fill),
    .i_fill_tag   (r_mem_addr),
    .i_fill_data  (mem_rdata),
    .i_snoop_wr   (w_snoop),
    .i_snoop_tag  (r_mem_addr)
  );

  // Sequencer FSM. instr_valid and dack are set on the transition into the
  // cycle where they are meant to be seen, so they stay single-cycle pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_retired     <= '0;
      r_mem_addr    <= '0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_wdata   <= '0;
      r_drdata      <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_dack        <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      r_dack        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (w_pc_bad) begin
            r_state  <= S_FAULT;
            r_fault  <= 1'b1;
            r_halted <= 1'b1;
          end else if (w_hit) begin
            r_instr       <= pick_half(w_buf_data, r_pc[1]);
            r_instr_valid <= 1'b1;
            r_state       <= S_ISSUE;
          end else begin
            r_mem_rd   <= 1'b1;
            r_mem_addr <= w_pc_word;
            r_state    <= S_FWAIT;
          end
        end
        S_FWAIT: begin
          if (mem_ready) begin
            r_mem_rd      <= 1'b0;
            r_instr       <= pick_half(mem_rdata, r_pc[1]);
            r_instr_valid <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          // A pending data access is served before the instruction may retire.
          if (dreq) begin
            if (w_daddr_bad) begin
              r_state  <= S_FAULT;
              r_fault  <= 1'b1;
              r_halted <= 1'b1;
            end else begin
              r_mem_rd    <= ~dwe;
              r_mem_wr    <= dwe;
              r_mem_addr  <= daddr[ADDR_W+OFS_W-1:OFS_W];
              r_mem_wdata <= dwdata;
              r_state     <= S_DWAIT;
            end
          end else if (exec_done) begin
            r_retired <= r_retired + 32'd1;
            if (exec_halt) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc    <= exec_branch ? (exec_target & ~32'd1) : (r_pc + 32'(HALF_BYTES));
              r_state <= S_FETCH;
            end
          end
        end
        S_DWAIT: begin
          if (mem_ready) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_dack   <= 1'b1;
            r_drdata <= r_mem_wr ? 32'd0 : mem_rdata;
            r_state  <= S_EXEC;
          end
        end
        S_HALT, S_FAULT: begin
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_rd      = r_mem_rd;
  assign mem_wr      = r_mem_wr;
  assign mem_wdata   = r_mem_wdata;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign drdata      = r_drdata;
  assign dack        = r_dack;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign retired     = r_retired;

endmodule

// File: tb/tb_emu_fetch_sequencer.sv
// Scoreboard bench for emu_fetch_sequencer: a driver plays the execute unit,
// a memory model answers the port, and a monitor pops expected instructions
// and load data whenever the sequencer presents them.
module tb_emu_fetch_sequencer;

  localparam int ADDR_W    = 10;
  localparam int MEM_WORDS = 1 << ADDR_W;
  localparam int OP_RUN     = 0;
  localparam int OP_DONE    = 1;
  localparam int OP_BRANCH  = 2;
  localparam int OP_HALT    = 3;
  localparam int OP_LOAD    = 4;
  localparam int OP_STORE   = 5;
  localparam int OP_BADDATA = 6;

  logic              clock = 1'b0;
  logic              reset, run;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd, mem_wr, mem_ready;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [15:0]       instr;
  logic              instr_valid;
  logic [31:0]       pc;
  logic              exec_done, exec_branch, exec_halt;
  logic [31:0]       exec_target;
  logic              dreq, dwe;
  logic [31:0]       daddr, dwdata, drdata;
  logic              dack, halted, fault;
  logic [31:0]       retired;

  always #5 clock = ~clock;

  emu_fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .run(run),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .exec_done(exec_done), .exec_branch(exec_branch), .exec_target(exec_target),
    .exec_halt(exec_halt),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .drdata(drdata), .dack(dack), .halted(halted), .fault(fault), .retired(retired)
  );

  int tests = 0;
  int failures = 0;

  // Memory: a request is held for holdCycles cycles (1 = zero wait).
  logic [31:0]       mem [MEM_WORDS];
  int                holdCycles = 1;
  int                waitCnt = 0;
  logic              preloadEn = 1'b0;
  logic [ADDR_W-1:0] preloadAddr = '0;
  logic [31:0]       preloadData = '0;

  assign mem_ready = (mem_rd || mem_wr) && (waitCnt >= holdCycles - 1);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (preloadEn) mem[preloadAddr] <= preloadData;
    else if (mem_wr && mem_ready) mem[mem_addr] <= mem_wdata;
    if ((mem_rd || mem_wr) && !mem_ready) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  // Bus activity counters used to tell buffer hits from refetches.
  int                rdRises = 0;
  int                rdHigh = 0;
  int                wrHigh = 0;
  logic              prevRd = 1'b0;
  logic [ADDR_W-1:0] lastRdAddr = '0;

  always @(negedge clock) begin
    if (mem_rd) begin
      rdHigh = rdHigh + 1;
      if (!prevRd) begin
        rdRises = rdRises + 1;
        lastRdAddr = mem_addr;
      end
    end
    if (mem_wr) wrHigh = wrHigh + 1;
    prevRd = mem_rd;
  end

  typedef struct packed {
    logic        isData;
    logic [31:0] value;
    logic [31:0] pc;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    tests++;
    failures++;
    $display("[TB] FAIL %s: got no/unexpected event, expected the specified behaviour", name);
  endtask

  // Monitor: every instruction issue and data completion must match the
  // oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (instr_valid) begin
        if (expQ.size() == 0 || expQ[0].isData) reportFail("unexpectedInstr");
        else begin
          monE = expQ.pop_front();
          checkOutput("instr", {16'h0, instr}, monE.value);
          checkOutput("instrPc", pc, monE.pc);
        end
      end
      if (dack) begin
        if (expQ.size() == 0 || !expQ[0].isData) reportFail("unexpectedDack");
        else begin
          monE = expQ.pop_front();
          checkOutput("drdata", drdata, monE.value);
        end
      end
      if (mem_rd && mem_wr) reportFail("rdWrExclusive");
    end
  end

  // Reference model state: architectural PC, retire count, memory image and
  // which word (if any) the sequencer may reuse without refetching.
  logic [31:0]       refMem [MEM_WORDS];
  logic [31:0]       mPc, mRetired;
  logic              bufValid;
  logic [ADDR_W-1:0] bufTag;
  logic              pendBad, pendHit;
  logic [ADDR_W-1:0] pendWord;
  int                snapRises, snapHigh, snapWr;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setWord(input int a, input logic [31:0] d);
    refMem[a] = d;
    preloadAddr = a[ADDR_W-1:0];
    preloadData = d;
    preloadEn = 1'b1;
    tick();
    preloadEn = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    run = 0; exec_done = 0; exec_branch = 0; exec_halt = 0; exec_target = 0;
    dreq = 0; dwe = 0; daddr = 0; dwdata = 0;
    tick();
    reset = 1'b0;
    expQ.delete();
    mPc = 32'h0;
    mRetired = 0;
    bufValid = 1'b0;
    bufTag = '0;
  endtask

  task automatic checkResetState();
    checkOutput("rstPc", pc, 32'h0);
    checkOutput("rstRetired", retired, 32'h0);
    checkOutput("rstFlags", {26'h0, mem_rd, mem_wr, instr_valid, dack, halted, fault}, 32'h0);
    checkOutput("rstMemAddr", 32'(mem_addr), 32'h0);
    checkOutput("rstWdata", mem_wdata, 32'h0);
    checkOutput("rstDrdata", drdata, 32'h0);
    checkOutput("rstInstr", {16'h0, instr}, 32'h0);
  endtask

  task automatic waitInstr(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (instr_valid) begin
        lat = i + 1;
        break;
      end
    end
    if (lat == 0) reportFail("instrTimeout");
    else tick();
  endtask

  task automatic waitDack();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (dack) begin
        seen = 1;
        break;
      end
    end
    if (!seen) reportFail("dackTimeout");
  endtask

  task automatic prepFetch();
    logic [31:0] w;
    exp_t e;
    pendBad = (mPc[31:ADDR_W+2] != 0) || mPc[0];
    if (!pendBad) begin
      pendWord = mPc[ADDR_W+1:2];
      pendHit = bufValid && (bufTag == pendWord);
      w = refMem[pendWord];
      e.isData = 1'b0;
      e.pc = mPc;
      e.value = mPc[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
      expQ.push_back(e);
      bufValid = 1'b1;
      bufTag = pendWord;
    end
    snapRises = rdRises;
  endtask

  task automatic endFetch(output int lat);
    lat = 0;
    if (pendBad) begin
      repeat (4) tick();
      checkOutput("fetchFault", 32'(fault), 32'h1);
      checkOutput("fetchFaultHalted", 32'(halted), 32'h1);
      checkOutput("fetchFaultNoRead", rdRises - snapRises, 32'h0);
    end else begin
      waitInstr(lat);
      if (pendHit) checkOutput("hitNoRead", rdRises - snapRises, 32'h0);
      else begin
        checkOutput("missRead", rdRises - snapRises, 32'h1);
        checkOutput("missAddr", 32'(lastRdAddr), 32'(pendWord));
      end
      checkOutput("retired", retired, mRetired);
    end
  endtask

  task automatic applyStimulus(input int op, input logic [31:0] a, input logic [31:0] b, output int lat);
    exp_t e;
    logic [ADDR_W-1:0] wd;
    lat = 0;
    wd = a[ADDR_W+1:2];
    case (op)
      OP_RUN: begin
        prepFetch();
        run = 1'b1;
        tick();
        run = 1'b0;
        endFetch(lat);
      end
      OP_DONE, OP_BRANCH: begin
        mRetired = mRetired + 1;
        if (op == OP_BRANCH) mPc = a & ~32'd1;
        else mPc = mPc + 32'd2;
        prepFetch();
        exec_done = 1'b1;
        exec_branch = (op == OP_BRANCH);
        exec_target = a;
        tick();
        exec_done = 1'b0;
        exec_branch = 1'b0;
        endFetch(lat);
      end
      OP_HALT: begin
        mRetired = mRetired + 1;
        snapRises = rdRises;
        exec_done = 1'b1;
        exec_halt = 1'b1;
        exec_branch = b[0];
        exec_target = a;
        tick();
        exec_done = 1'b0;
        exec_halt = 1'b0;
        exec_branch = 1'b0;
        repeat (2) tick();
        checkOutput("haltHalted", 32'(halted), 32'h1);
        checkOutput("haltNoFault", 32'(fault), 32'h0);
        checkOutput("haltPc", pc, mPc);
        checkOutput("haltRetired", retired, mRetired);
        checkOutput("haltNoFetch", rdRises - snapRises, 32'h0);
      end
      OP_LOAD: begin
        e.isData = 1'b1;
        e.value = refMem[wd];
        e.pc = '0;
        expQ.push_back(e);
        snapHigh = rdHigh;
        dreq = 1'b1; dwe = 1'b0; daddr = a; dwdata = $urandom;
        tick();
        dreq = 1'b0;
        waitDack();
        checkOutput("loadAddr", 32'(lastRdAddr), 32'(wd));
      end
      OP_STORE: begin
        e.isData = 1'b1;
        e.value = '0;
        e.pc = '0;
        expQ.push_back(e);
        refMem[wd] = b;
        if (bufValid && bufTag == wd) bufValid = 1'b0;
        dreq = 1'b1; dwe = 1'b1; daddr = a; dwdata = b;
        tick();
        dreq = 1'b0;
        waitDack();
      end
      OP_BADDATA: begin
        snapRises = rdRises;
        snapWr = wrHigh;
        dreq = 1'b1; dwe = b[0]; daddr = a; dwdata = $urandom;
        tick();
        dreq = 1'b0;
        repeat (3) tick();
        checkOutput("dataFault", 32'(fault), 32'h1);
        checkOutput("dataFaultHalted", 32'(halted), 32'h1);
        checkOutput("dataFaultNoRead", rdRises - snapRises, 32'h0);
        checkOutput("dataFaultNoWrite", wrHigh - snapWr, 32'h0);
      end
      default: reportFail("badOp");
    endcase
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int r;
    bit seen;
    logic [31:0] a;
    reset = 1'b1;
    run = 0; exec_done = 0; exec_branch = 0; exec_halt = 0; exec_target = 0;
    dreq = 0; dwe = 0; daddr = 0; dwdata = 0;
    for (int i = 0; i < MEM_WORDS; i++) setWord(i, $urandom);
    setWord(0, 32'h2001_2002);
    setWord(16, 32'hDEAD_BEEF);
    doReset();
    checkResetState();

    // Sequential fetch: miss then buffer hit on the same word.
    holdCycles = 1;
    applyStimulus(OP_RUN, 32'h0, 32'h0, lat);
    checkOutput("missLatency", lat, 32'd3);
    applyStimulus(OP_DONE, $urandom, 32'h0, lat);
    checkOutput("hitLatency", lat, 32'd2);
    applyStimulus(OP_DONE, $urandom, 32'h0, lat);
    checkOutput("retiredTwo", retired, 32'd2);

    // Branch with odd target clears bit 0.
    applyStimulus(OP_BRANCH, 32'h0000_0011, 32'h0, lat);
    checkOutput("branchPc", pc, 32'h10);

    // Load with wait states.
    holdCycles = 3;
    applyStimulus(OP_LOAD, 32'h40, 32'h0, lat);
    checkOutput("loadHoldCycles", rdHigh - snapHigh, 32'd3);

    // Self-modifying store into the buffered word forces a refetch.
    holdCycles = 1;
    applyStimulus(OP_STORE, 32'h10, 32'h1234_5678, lat);
    applyStimulus(OP_DONE, $urandom, 32'h0, lat);
    checkOutput("smcInstr", {16'h0, instr}, 32'h1234);

    // Randomized mix of retires, branches, loads and stores.
    for (int n = 0; n < 150; n++) begin
      holdCycles = $urandom_range(1, 3);
      r = $urandom_range(0, 9);
      if (r < 4 && mPc < 32'd4000) applyStimulus(OP_DONE, $urandom, 32'h0, lat);
      else if (r < 6 || r < 4) applyStimulus(OP_BRANCH, 32'($urandom_range(0, 4095)), 32'h0, lat);
      else if (r < 8) applyStimulus(OP_LOAD, 32'($urandom_range(0, 1023) * 4), 32'h0, lat);
      else begin
        a = (r == 9) ? (mPc & ~32'd3) : 32'($urandom_range(0, 1023) * 4);
        applyStimulus(OP_STORE, a, $urandom, lat);
      end
    end

    // Halt wins over branch and is sticky against run.
    applyStimulus(OP_HALT, 32'($urandom_range(0, 4095)), 32'h1, lat);
    snapRises = rdRises;
    run = 1'b1;
    repeat (3) tick();
    run = 1'b0;
    repeat (2) tick();
    checkOutput("haltSticky", 32'(halted), 32'h1);
    checkOutput("haltRunIgnored", rdRises - snapRises, 32'h0);

    // Reset while a fetch is stalled in the memory.
    doReset();
    holdCycles = 1;
    applyStimulus(OP_RUN, 32'h0, 32'h0, lat);
    holdCycles = 8;
    exec_done = 1'b1; exec_branch = 1'b1; exec_target = 32'h200;
    tick();
    exec_done = 1'b0; exec_branch = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (mem_rd) begin
        seen = 1;
        break;
      end
    end
    if (!seen) reportFail("fwaitTimeout");
    checkOutput("fwaitAddr", 32'(mem_addr), 32'h80);
    doReset();
    checkResetState();
    holdCycles = 1;
    repeat (2) tick();

    // Misaligned data address faults without touching memory.
    doReset();
    applyStimulus(OP_RUN, 32'h0, 32'h0, lat);
    applyStimulus(OP_BADDATA, 32'h42, 32'h1, lat);

    // Branch beyond the implemented memory faults on the next fetch.
    doReset();
    applyStimulus(OP_RUN, 32'h0, 32'h0, lat);
    applyStimulus(OP_BRANCH, 32'h0000_1000, 32'h0, lat);
    checkOutput("faultPc", pc, 32'h1000);

    repeat (2) tick();
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
